modbus_reg_responder: RTL and testbench
=======================================

# modbus_reg_responder

Receive-side counterpart of the periodic Modbus frame former: accepts 48-bit request frames (write-single-register 0x06, read-holding-registers 0x03) from the UART frame receiver, updates a 40-entry 16-bit register bank mapped at 300..339, and produces response frames for the UART transmitter. It sits between the serial frame deframer and the control logic that consumes the register bank.

## Interface
- SLAVE_ADDR, 2, station address that is answered
- BASE_ADDR, 300, register address of bank entry 0
- NUM_REGS, 40, bank depth
- MAX_READ, 16, largest legal 0x03 count
- clk  in  1  system clock
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- rx_data  in  48  request: [7:0] slave, [15:8] function, [31:16] register address, [47:32] value (0x06) or count (0x03)
- rx_valid  in  1  one-cycle strobe; rx_data valid in that cycle
- reg_out  out  NUM_REGS*16  flat bank; entry k at [16k+15:16k]
- wr_pulse  out  1  one-cycle pulse when a bank entry is written
- tx_data  out  48  response, same field layout as rx_data
- tx_valid  out  1  response valid; held until accepted
- tx_ready  in  1  transmitter accepts when tx_valid && tx_ready at a rising edge
- busy  out  1  high in every state except IDLE
- frame_cnt  out  16  requests addressed to SLAVE_ADDR and accepted; wraps
- err_cnt  out  16  exceptions plus dropped frames; wraps

## Operation
- States: IDLE, DECODE, WRITE, READ, RESP.
- IDLE: on rx_valid latch rx_data, -> DECODE.
- DECODE: slave != SLAVE_ADDR -> IDLE, no response, no count. Else frame_cnt+1 and:
  - 0x06: addr in [BASE_ADDR, BASE_ADDR+NUM_REGS) -> WRITE; else exception 2.
  - 0x03: count 0 or > MAX_READ -> exception 3; addr < BASE_ADDR or addr+count (17-bit sum) > BASE_ADDR+NUM_REGS -> exception 2; else idx=addr-BASE_ADDR, remaining=count, -> READ.
  - other function -> exception 1.
  - Exception: tx_data = {16'h0000, code, func|8'h80, SLAVE_ADDR}, err_cnt+1, -> RESP.
- WRITE: bank[idx] <= value, wr_pulse=1, tx_data = request echo, -> RESP.
- READ: tx_data = {bank[idx], BASE_ADDR+idx, 8'h03, SLAVE_ADDR}, idx+1, remaining-1, -> RESP.
- RESP: tx_valid=1; on handshake: remaining>0 -> READ, else IDLE.
- rx_valid in any state other than IDLE: frame dropped, err_cnt+1, no other effect.
- Reset: state IDLE; bank all 0; tx_data 0, tx_valid 0, wr_pulse 0, busy 0, counters 0. Reset mid-read aborts the burst; no further words.

## Timing
- rx_valid sampled at edge N; DECODE during N..N+1.
- Write: bank entry and reg_out updated and wr_pulse high after edge N+2; tx_valid high after edge N+2.
- Exception: tx_valid high after edge N+1.
- Read: first word tx_valid high after N+2; handshake at edge M -> next word tx_valid after M+2 (one low cycle between words).
- tx_data stable while tx_valid high and not accepted.
- tx_ready constantly high: each word accepted on the first edge it is valid.

## Structure
- Package modbus_pkg: field offsets, function codes 0x03/0x06, exception codes 1/2/3, state enum, frame width 48.
- Sub-module modbus_reg_bank: NUM_REGS x 16, one sync write port, one async read port, flat reg_out, synchronous clear on rst_n.

## Test plan
- {val 0x1234, addr 305, func 6, slave 2}, tx_ready=1 -> reg_out[95:80]=0x1234, one wr_pulse, echo frame, frame_cnt=1.
- Read addr 338 count 2 after writing 338=0xAAAA, 339=0x5555 -> two frames {0xAAAA,338,3,2},{0x5555,339,3,2}, busy low after second handshake.
- Read addr 339 count 2 -> exception {0,2,0x83,2}, err_cnt+1; func 0x10 -> {0,1,0x90,2}; count 0 -> code 3.
- Slave 5 request -> no response, no counters change, bank unchanged.
- tx_ready low 10 cycles during read burst, second rx_valid during it -> tx_data held, frame dropped, err_cnt+1; rst_n low mid-burst -> all outputs and bank zero next edge.

Source files
------------

// File: rtl/modbus_pkg.sv
// Shared types and constants for the Modbus register responder: frame layout,
// function/exception codes and the controller state encoding.
package modbus_pkg;

   localparam int FRAME_W  = 48;
   localparam int SLAVE_LSB = 0;
   localparam int FUNC_LSB  = 8;
   localparam int ADDR_LSB  = 16;
   localparam int DATA_LSB  = 32;

   localparam logic [7:0] FUNC_READ  = 8'h03;
   localparam logic [7:0] FUNC_WRITE = 8'h06;
   localparam logic [7:0] EXC_FLAG   = 8'h80;

   localparam logic [7:0] EXC_NONE  = 8'd0;
   localparam logic [7:0] EXC_FUNC  = 8'd1;
   localparam logic [7:0] EXC_ADDR  = 8'd2;
   localparam logic [7:0] EXC_VALUE = 8'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_WRITE,
      ST_READ,
      ST_RESP
   } state_t;

   // Packed MSB-first so the fields land at the offsets above.
   typedef struct packed {
      logic [15:0] data;
      logic [15:0] addr;
      logic [7:0]  func;
      logic [7:0]  slave;
   } frame_t;

   function automatic frame_t exc_frame(input logic [7:0] func,
                                        input logic [7:0] code,
                                        input logic [7:0] slave);
      frame_t f;
      f.data  = 16'h0000;
      f.addr  = {8'h00, code};
      f.func  = func | EXC_FLAG;
      f.slave = slave;
      return f;
   endfunction

endpackage

// File: rtl/modbus_reg_responder_if.sv
// Request/response frame bus between the UART deframer/transmitter and the responder.
interface modbus_reg_responder_if;
   import modbus_pkg::*;

   frame_t rx_data;
   logic   rx_valid;
   frame_t tx_data;
   logic   tx_valid;
   logic   tx_ready;

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  tx_ready,
      output tx_data,
      output tx_valid
   );

   modport master (
      output rx_data,
      output rx_valid,
      output tx_ready,
      input  tx_data,
      input  tx_valid
   );

endinterface

// File: rtl/modbus_reg_bank.sv
// Register bank: one synchronous write port, one combinational read port and a
// flat view of every entry; cleared synchronously by rst_n.
module modbus_reg_bank #(
   parameter int NUM_REGS = 40,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [IDX_W-1:0]         widx,
   input  logic [15:0]              wdata,
   input  logic [IDX_W-1:0]         ridx,
   output logic [15:0]              rdata,
   output logic [NUM_REGS*16-1:0]   reg_out
);

   logic [15:0] mem_q [NUM_REGS];
   logic [15:0] mem_d [NUM_REGS];

   always_comb begin
      mem_d = mem_q;
      if (we && (int'(widx) < NUM_REGS)) begin
         mem_d[widx] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            mem_q[k] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = (int'(ridx) < NUM_REGS) ? mem_q[ridx] : 16'h0000;

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
      assign reg_out[16*k +: 16] = mem_q[k];
   end

endmodule

// File: rtl/modbus_reg_responder.sv
// Modbus slave for write-single-register (0x06) and read-holding-registers (0x03)
// against a register bank; one response word per handshake.
module modbus_reg_responder
   import modbus_pkg::*;
#(
   parameter int SLAVE_ADDR = 2,
   parameter int BASE_ADDR  = 300,
   parameter int NUM_REGS   = 40,
   parameter int MAX_READ   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   modbus_reg_responder_if.slave    bus,
   output logic [NUM_REGS*16-1:0]   reg_out,
   output logic                     wr_pulse,
   output logic                     busy,
   output logic [15:0]              frame_cnt,
   output logic [15:0]              err_cnt
);

   localparam int          IDX_W  = $clog2(NUM_REGS);
   localparam int          REM_W  = $clog2(MAX_READ + 1);
   localparam logic [7:0]  SLAVE8 = 8'(SLAVE_ADDR);
   localparam logic [15:0] BASE16 = 16'(BASE_ADDR);
   localparam logic [15:0] MAX16  = 16'(MAX_READ);
   localparam logic [16:0] END17  = 17'(BASE_ADDR + NUM_REGS);

   state_t           state_q, state_d;
   frame_t           req_q, req_d;
   frame_t           tx_data_q, tx_data_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic             wr_pulse_q, wr_pulse_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic [15:0]      err_cnt_q, err_cnt_d;

   logic             match;
   logic [7:0]       exc_code;
   logic [16:0]      read_end;
   logic             bank_we;
   logic [15:0]      bank_rdata;

   modbus_reg_bank #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (bank_we),
      .widx    (idx_q),
      .wdata   (req_q.data),
      .ridx    (idx_q),
      .rdata   (bank_rdata),
      .reg_out (reg_out)
   );

   // Request classification on the latched frame; exc_code 0 means legal.
   always_comb begin
      match    = (req_q.slave == SLAVE8);
      exc_code = EXC_NONE;
      read_end = {1'b0, req_q.addr} + {1'b0, req_q.data};
      case (req_q.func)
         FUNC_WRITE: begin
            if ((req_q.addr < BASE16) || ({1'b0, req_q.addr} >= END17)) begin
               exc_code = EXC_ADDR;
            end
         end
         FUNC_READ: begin
            if ((req_q.data == 16'h0000) || (req_q.data > MAX16)) begin
               exc_code = EXC_VALUE;
            end else if ((req_q.addr < BASE16) || (read_end > END17)) begin
               exc_code = EXC_ADDR;
            end
         end
         default: exc_code = EXC_FUNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (bus.rx_valid) state_d = ST_DECODE;
         ST_DECODE: begin
            if (!match) begin
               state_d = ST_IDLE;
            end else if (exc_code != EXC_NONE) begin
               state_d = ST_RESP;
            end else if (req_q.func == FUNC_WRITE) begin
               state_d = ST_WRITE;
            end else begin
               state_d = ST_READ;
            end
         end
         ST_WRITE:  state_d = ST_RESP;
         ST_READ:   state_d = ST_RESP;
         ST_RESP:   if (bus.tx_ready) state_d = (rem_q != '0) ? ST_READ : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Datapath and control outputs; a frame arriving while busy is only counted.
   always_comb begin
      req_d       = req_q;
      tx_data_d   = tx_data_q;
      idx_d       = idx_q;
      rem_d       = rem_q;
      wr_pulse_d  = 1'b0;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      bank_we     = 1'b0;
      busy        = (state_q != ST_IDLE);
      bus.tx_valid = (state_q == ST_RESP);
      bus.tx_data  = tx_data_q;

      if (bus.rx_valid && (state_q != ST_IDLE)) begin
         err_cnt_d = err_cnt_d + 16'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.rx_valid) req_d = bus.rx_data;
         end
         ST_DECODE: begin
            if (match) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               idx_d       = IDX_W'(req_q.addr - BASE16);
               rem_d       = '0;
               if (exc_code != EXC_NONE) begin
                  tx_data_d = exc_frame(req_q.func, exc_code, SLAVE8);
                  err_cnt_d = err_cnt_d + 16'd1;
               end else if (req_q.func == FUNC_READ) begin
                  rem_d = REM_W'(req_q.data);
               end
            end
         end
         ST_WRITE: begin
            bank_we    = 1'b1;
            wr_pulse_d = 1'b1;
            tx_data_d  = req_q;
         end
         ST_READ: begin
            tx_data_d.data  = bank_rdata;
            tx_data_d.addr  = BASE16 + 16'(idx_q);
            tx_data_d.func  = FUNC_READ;
            tx_data_d.slave = SLAVE8;
            idx_d           = idx_q + IDX_W'(1);
            rem_d           = rem_q - REM_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_q       <= '0;
         tx_data_q   <= '0;
         idx_q       <= '0;
         rem_q       <= '0;
         wr_pulse_q  <= 1'b0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         req_q       <= req_d;
         tx_data_q   <= tx_data_d;
         idx_q       <= idx_d;
         rem_q       <= rem_d;
         wr_pulse_q  <= wr_pulse_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign wr_pulse  = wr_pulse_q;
   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_modbus_reg_responder.sv
// Directed bench for modbus_reg_responder with a response scoreboard.
module tb_modbus_reg_responder;

   localparam int NUM_REGS = 40;

   logic                   clk;
   logic                   rst_n;
   logic [NUM_REGS*16-1:0] reg_out;
   logic                   wr_pulse;
   logic                   busy;
   logic [15:0]            frame_cnt;
   logic [15:0]            err_cnt;

   modbus_reg_responder_if bus ();

   modbus_reg_responder #(
      .SLAVE_ADDR (2),
      .BASE_ADDR  (300),
      .NUM_REGS   (NUM_REGS),
      .MAX_READ   (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .reg_out   (reg_out),
      .wr_pulse  (wr_pulse),
      .busy      (busy),
      .frame_cnt (frame_cnt),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_err = 0;
   int            wr_seen = 0;
   logic [47:0]   exp_q[$];

   function automatic logic [47:0] mk(input logic [15:0] data, input logic [15:0] addr,
                                      input logic [7:0] func, input logic [7:0] slave);
      return {data, addr, func, slave};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every accepted response must match the oldest expected frame.
   always @(negedge clk) begin
      if (rst_n && bus.tx_valid && bus.tx_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL unexpected_resp: observed %0h expected none", bus.tx_data);
         end else begin
            chk("resp", 64'(bus.tx_data), 64'(exp_q.pop_front()));
         end
      end
      if (rst_n && wr_pulse) wr_seen++;
   end

   task automatic send(input logic [47:0] f);
      @(posedge clk); #1;
      bus.rx_data  = f;
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: observed busy stuck expected idle", tag);
      end
   endtask

   task automatic wait_tv(input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.tx_valid) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: observed tx_valid low expected high", tag);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.rx_data  = '0;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx_valid", 64'(bus.tx_valid), 0);
      chk("rst_tx_data", 64'(bus.tx_data), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_wr_pulse", 64'(wr_pulse), 0);
      chk("rst_frame_cnt", 64'(frame_cnt), 0);
      chk("rst_err_cnt", 64'(err_cnt), 0);
      chk("rst_bank", 64'(|reg_out), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Write 305 = 0x1234 with latency checks.
      exp_q.push_back(mk(16'h1234, 16'd305, 8'h06, 8'h02));
      send(mk(16'h1234, 16'd305, 8'h06, 8'h02));
      @(negedge clk);
      @(negedge clk);
      chk("wr_tv_early", 64'(bus.tx_valid), 0);
      chk("wr_pulse_early", 64'(wr_pulse), 0);
      @(negedge clk);
      chk("wr_tv", 64'(bus.tx_valid), 1);
      chk("wr_pulse", 64'(wr_pulse), 1);
      chk("wr_bank305", 64'(reg_out[95:80]), 64'h1234);
      wait_idle("wr_idle");
      chk("wr_frame_cnt", 64'(frame_cnt), 1);
      chk("wr_pulse_count", 64'(wr_seen), 1);

      exp_q.push_back(mk(16'hAAAA, 16'd338, 8'h06, 8'h02));
      send(mk(16'hAAAA, 16'd338, 8'h06, 8'h02));
      wait_idle("wr338_idle");
      exp_q.push_back(mk(16'h5555, 16'd339, 8'h06, 8'h02));
      send(mk(16'h5555, 16'd339, 8'h06, 8'h02));
      wait_idle("wr339_idle");
      chk("bank338", 64'(reg_out[38*16 +: 16]), 64'hAAAA);
      chk("bank339", 64'(reg_out[39*16 +: 16]), 64'h5555);
      chk("wr_pulse_count3", 64'(wr_seen), 3);

      // Two-word read burst: one idle cycle between words.
      exp_q.push_back(mk(16'hAAAA, 16'd338, 8'h03, 8'h02));
      exp_q.push_back(mk(16'h5555, 16'd339, 8'h03, 8'h02));
      send(mk(16'd2, 16'd338, 8'h03, 8'h02));
      @(negedge clk);
      @(negedge clk);
      chk("rd_tv_n2", 64'(bus.tx_valid), 0);
      @(negedge clk);
      chk("rd_tv_w1", 64'(bus.tx_valid), 1);
      @(negedge clk);
      chk("rd_tv_gap", 64'(bus.tx_valid), 0);
      @(negedge clk);
      chk("rd_tv_w2", 64'(bus.tx_valid), 1);
      @(negedge clk);
      chk("rd_busy_end", 64'(busy), 0);
      chk("rd_frame_cnt", 64'(frame_cnt), 4);

      // Exceptions; the first also checks the one-cycle decode latency.
      exp_q.push_back(mk(16'h0, 16'h0002, 8'h83, 8'h02));
      send(mk(16'd2, 16'd339, 8'h03, 8'h02));
      @(negedge clk);
      @(negedge clk);
      chk("exc_tv", 64'(bus.tx_valid), 1);
      wait_idle("exc2_idle");
      chk("exc2_err_cnt", 64'(err_cnt), 1);
      exp_q.push_back(mk(16'h0, 16'h0001, 8'h90, 8'h02));
      send(mk(16'h1, 16'd305, 8'h10, 8'h02));
      wait_idle("exc1_idle");
      exp_q.push_back(mk(16'h0, 16'h0003, 8'h83, 8'h02));
      send(mk(16'd0, 16'd305, 8'h03, 8'h02));
      wait_idle("cnt0_idle");
      exp_q.push_back(mk(16'h0, 16'h0003, 8'h83, 8'h02));
      send(mk(16'd17, 16'd300, 8'h03, 8'h02));
      wait_idle("cnt17_idle");
      exp_q.push_back(mk(16'h0, 16'h0002, 8'h86, 8'h02));
      send(mk(16'h7777, 16'd340, 8'h06, 8'h02));
      wait_idle("wr340_idle");
      exp_q.push_back(mk(16'h0, 16'h0002, 8'h86, 8'h02));
      send(mk(16'h7777, 16'd299, 8'h06, 8'h02));
      wait_idle("wr299_idle");
      exp_q.push_back(mk(16'h5555, 16'd339, 8'h03, 8'h02));
      send(mk(16'd1, 16'd339, 8'h03, 8'h02));
      wait_idle("rd339_idle");
      chk("exc_err_cnt", 64'(err_cnt), 6);
      chk("exc_frame_cnt", 64'(frame_cnt), 11);
      chk("exc_no_write", 64'(wr_seen), 3);

      // Foreign station: ignored completely.
      send(mk(16'hFFFF, 16'd305, 8'h06, 8'h05));
      wait_idle("foreign_idle");
      repeat (3) @(negedge clk);
      chk("foreign_frame_cnt", 64'(frame_cnt), 11);
      chk("foreign_err_cnt", 64'(err_cnt), 6);
      chk("foreign_bank305", 64'(reg_out[95:80]), 64'h1234);
      chk("foreign_no_write", 64'(wr_seen), 3);

      // Back-pressure with a frame arriving mid-burst.
      @(posedge clk); #1;
      bus.tx_ready = 1'b0;
      exp_q.push_back(mk(16'hAAAA, 16'd338, 8'h03, 8'h02));
      exp_q.push_back(mk(16'h5555, 16'd339, 8'h03, 8'h02));
      send(mk(16'd2, 16'd338, 8'h03, 8'h02));
      wait_tv("bp_first");
      bus.rx_data = mk(16'h4321, 16'd301, 8'h06, 8'h02);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         bus.rx_valid = (i == 3);
         @(negedge clk);
         chk("bp_hold_tv", 64'(bus.tx_valid), 1);
         chk("bp_hold_data", 64'(bus.tx_data), 64'(mk(16'hAAAA, 16'd338, 8'h03, 8'h02)));
      end
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b1;
      wait_idle("bp_idle");
      chk("drop_err_cnt", 64'(err_cnt), 7);
      chk("drop_frame_cnt", 64'(frame_cnt), 12);
      chk("drop_bank301", 64'(reg_out[1*16 +: 16]), 0);

      // Reset in the middle of a stalled burst.
      @(posedge clk); #1;
      bus.tx_ready = 1'b0;
      send(mk(16'd2, 16'd338, 8'h03, 8'h02));
      wait_tv("mid_rst_first");
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mrst_tx_valid", 64'(bus.tx_valid), 0);
      chk("mrst_tx_data", 64'(bus.tx_data), 0);
      chk("mrst_busy", 64'(busy), 0);
      chk("mrst_frame_cnt", 64'(frame_cnt), 0);
      chk("mrst_err_cnt", 64'(err_cnt), 0);
      chk("mrst_bank", 64'(|reg_out), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.tx_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("post_rst_tv", 64'(bus.tx_valid), 0);
      chk("sb_empty", 64'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
